// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle instruction fetch stage.
// Holds the PC, reads instruction memory over a ready handshake and
// presents the held instruction, its opcode, Pc and PcPlus4 to decode.
// A misaligned redirect target parks the unit in HALT until reset.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PcSrc,
   input  logic [31:0] PcTarget,
   input  logic        Stall,
   output logic        Imem_Req,
   output logic [31:0] Imem_Addr,
   input  logic        Imem_Ready,
   input  logic [31:0] Imem_Rdata,
   output logic [31:0] Instr,
   output logic [6:0]  Op,
   output logic [31:0] Pc,
   output logic [31:0] PcPlus4,
   output logic        Instr_Valid,
   output logic        Misalign_Err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t state;

   logic redirect_misaligned;

   // Decode-facing views derived directly from the held registers.
   assign Imem_Addr           = Pc;
   assign Op                  = Instr[6:0];
   assign PcPlus4             = Pc + 32'd4;
   assign redirect_misaligned = PcSrc && (PcTarget[1:0] != 2'b00);

   // Fetch sequencer: request, capture on ready, then hand off or redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         Pc           <= RESET_PC;
         Instr        <= NOP_INSTR;
         Instr_Valid  <= 1'b0;
         Imem_Req     <= 1'b0;
         Misalign_Err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Imem_Req <= 1'b1;
               state    <= FETCH;
            end
            FETCH: begin
               if (Imem_Ready) begin
                  Instr       <= Imem_Rdata;
                  Instr_Valid <= 1'b1;
                  Imem_Req    <= 1'b0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (!Stall) begin
                  Instr       <= NOP_INSTR;
                  Instr_Valid <= 1'b0;
                  if (redirect_misaligned) begin
                     Misalign_Err <= 1'b1;
                     state        <= HALT;
                  end else begin
                     Pc       <= PcSrc ? PcTarget : PcPlus4;
                     Imem_Req <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus randomized checks of instr_fetch_unit
// against a transaction-level reference model.
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        PcSrc;
   logic [31:0] PcTarget;
   logic        Stall;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic        Imem_Ready;
   logic [31:0] Imem_Rdata;
   logic [31:0] Instr;
   logic [6:0]  Op;
   logic [31:0] Pc;
   logic [31:0] PcPlus4;
   logic        Instr_Valid;
   logic        Misalign_Err;

   int tests;
   int failures;

   // Reference model: "waiting for memory", "holding a word", "halted".
   logic        mWaiting;
   logic        mHolding;
   logic        mHalted;
   logic [31:0] mPc;
   logic [31:0] mInstr;
   logic        mErr;

   instr_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .PcSrc        (PcSrc),
      .PcTarget     (PcTarget),
      .Stall        (Stall),
      .Imem_Req     (Imem_Req),
      .Imem_Addr    (Imem_Addr),
      .Imem_Ready   (Imem_Ready),
      .Imem_Rdata   (Imem_Rdata),
      .Instr        (Instr),
      .Op           (Op),
      .Pc           (Pc),
      .PcPlus4      (PcPlus4),
      .Instr_Valid  (Instr_Valid),
      .Misalign_Err (Misalign_Err)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count it and report any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model.
   task automatic checkAll(input string tag);
      checkOutput({tag, ".req"},   32'(Imem_Req),     32'(mWaiting));
      checkOutput({tag, ".addr"},  Imem_Addr,         mPc);
      checkOutput({tag, ".pc"},    Pc,                mPc);
      checkOutput({tag, ".pc4"},   PcPlus4,           mPc + 32'd4);
      checkOutput({tag, ".instr"}, Instr,             mInstr);
      checkOutput({tag, ".op"},    32'(Op),           32'(mInstr[6:0]));
      checkOutput({tag, ".valid"}, 32'(Instr_Valid),  32'(mHolding));
      checkOutput({tag, ".err"},   32'(Misalign_Err), 32'(mErr));
   endtask

   // One clock cycle with the given inputs; the model advances on the edge.
   task automatic applyStimulus(input logic rdy, input logic [31:0] rdata, input logic stall,
                                input logic pcsrc, input logic [31:0] target, input string tag);
      Imem_Ready = rdy;
      Imem_Rdata = rdata;
      Stall      = stall;
      PcSrc      = pcsrc;
      PcTarget   = target;
      @(posedge clk);
      if (mHalted) begin
         // only reset leaves the halted condition
      end else if (mWaiting) begin
         if (rdy) begin
            mInstr   = rdata;
            mHolding = 1'b1;
            mWaiting = 1'b0;
         end
      end else if (mHolding) begin
         if (!stall) begin
            mInstr   = NOP;
            mHolding = 1'b0;
            if (pcsrc && (target % 4 != 0)) begin
               mErr    = 1'b1;
               mHalted = 1'b1;
            end else begin
               mPc      = pcsrc ? target : mPc + 32'd4;
               mWaiting = 1'b1;
            end
         end
      end else begin
         mWaiting = 1'b1;
      end
      @(negedge clk);
      checkAll(tag);
   endtask

   // Assert reset mid-cycle, check the immediate effect, offer a stray
   // ready pulse while held, then release on a falling edge.
   task automatic applyReset(input string tag);
      rst_n = 1'b0;
      #1;
      mWaiting = 1'b0;
      mHolding = 1'b0;
      mHalted  = 1'b0;
      mPc      = 32'h0;
      mInstr   = NOP;
      mErr     = 1'b0;
      checkAll({tag, ".async"});
      Imem_Ready = 1'b1;
      Imem_Rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      checkAll({tag, ".held"});
      Imem_Ready = 1'b0;
      rst_n = 1'b1;
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      logic [31:0] rnd;
      logic [31:0] tgt;
      tests    = 0;
      failures = 0;
      rst_n      = 1'b0;
      PcSrc      = 1'b0;
      PcTarget   = 32'h0;
      Stall      = 1'b0;
      Imem_Ready = 1'b0;
      Imem_Rdata = 32'h0;
      @(negedge clk);

      applyReset("reset");
      checkOutput("reset.opConst", 32'(Op), 32'h13);
      checkOutput("reset.pc4Const", PcPlus4, 32'h4);

      // Sequential zero-wait fetches; ready in the IDLE cycle is ignored.
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, "cycle1");
      checkOutput("cycle1.reqConst", 32'(Imem_Req), 32'h1);
      applyStimulus(1'b1, 32'h0000_2083, 1'b0, 1'b0, 32'h0, "seq0");
      checkOutput("seq0.opConst", 32'(Op), 32'h03);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "seq0.adv");
      // Three wait states at Pc=4.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, "wait");
      checkOutput("wait.addrConst", Imem_Addr, 32'h4);
      applyStimulus(1'b1, 32'h0011_2023, 1'b0, 1'b0, 32'h0, "seq1");
      checkOutput("seq1.opConst", 32'(Op), 32'h23);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "seq1.adv");
      applyStimulus(1'b1, 32'h0020_81B3, 1'b0, 1'b0, 32'h0, "seq2");
      checkOutput("seq2.opConst", 32'(Op), 32'h33);
      checkOutput("seq2.pcConst", Pc, 32'h8);

      // Stall in ISSUE, with a redirect presented that must be ignored.
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h44, "stall");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, "redir");
      checkOutput("redir.addrConst", Imem_Addr, 32'h40);
      applyStimulus(1'b1, 32'h0000_006F, 1'b0, 1'b0, 32'h0, "jal");
      checkOutput("jal.opConst", 32'(Op), 32'h6F);

      // Redirect to the top word, then wrap to zero.
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, "top");
      checkOutput("top.pc4Const", PcPlus4, 32'h0);
      applyStimulus(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, "top.fetch");
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "wrap");
      checkOutput("wrap.pcConst", Pc, 32'h0);
      applyStimulus(1'b1, 32'h0000_2083, 1'b0, 1'b0, 32'h0, "wrap.fetch");

      // Misaligned redirect halts until reset.
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'h42, "misalign");
      checkOutput("misalign.errConst", 32'(Misalign_Err), 32'h1);
      for (int i = 0; i < 20; i++) begin
         rnd = $urandom;
         applyStimulus(rnd[0], $urandom, rnd[1], rnd[2], 32'h40, "halt");
      end
      applyReset("halt.reset");

      // Walk to Pc=0x10 and reset while the request is outstanding.
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "walk.start");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0, "walk.fetch");
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "walk.adv");
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "walk.wait");
      checkOutput("walk.addrConst", Imem_Addr, 32'h10);
      applyReset("midfetch");

      // Randomized traffic with occasional misaligned targets and resets.
      for (int i = 0; i < 600; i++) begin
         rnd = $urandom;
         tgt = $urandom;
         if (rnd[7:4] != 4'd0)
            tgt[1:0] = 2'b00;
         if ((mHalted && rnd[10:8] == 3'd0) || rnd[17:11] == 7'd0)
            applyReset("rand.reset");
         else
            applyStimulus(rnd[1:0] != 2'b00, $urandom, rnd[3:2] == 2'b00,
                          rnd[19:18] == 2'b00, tgt, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch stage for the RISC-V single-cycle core. It sits directly upstream of Main_Decoder and the ALU decoder. It holds the program counter and issues requests to instruction memory over a ready handshake. It presents the fetched instruction, its `Op` field, `Pc` and `PcPlus4` to decode, and applies the next-PC selection (sequential or branch/jump target) that the execute path returns.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0): instruction value driven while no valid fetch is held.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PcSrc`  in  1  1 selects `PcTarget` as the next PC; 0 selects `PcPlus4`.
- `PcTarget`  in  32  branch/jump target from execute.
- `Stall`  in  1  1 holds the current instruction at decode.
- `Imem_Req`  out  1  instruction memory read request.
- `Imem_Addr`  out  32  read address; always equals `Pc`.
- `Imem_Ready`  in  1  read data valid this cycle; sampled only while `Imem_Req`=1.
- `Imem_Rdata`  in  32  instruction word.
- `Instr`  out  32  held instruction.
- `Op`  out  7  `Instr[6:0]`; feeds Main_Decoder `Op`.
- `Pc`  out  32  address of `Instr`.
- `PcPlus4`  out  32  `Pc + 4`, modulo 2^32.
- `Instr_Valid`  out  1  `Instr` is a real fetched instruction.
- `Misalign_Err`  out  1  sticky flag: a redirect target was not word-aligned.

## Operation
- FSM states are IDLE, FETCH, ISSUE and HALT. Reset state is IDLE.
- IDLE: `Imem_Req`=0. Moves to FETCH on the next edge unconditionally.
- FETCH: `Imem_Req`=1 and `Imem_Addr`=`Pc`.
  - Both stay stable until `Imem_Ready`=1.
  - On an edge with `Imem_Ready`=1: `Instr`<=`Imem_Rdata`, `Instr_Valid`<=1, go to ISSUE.
  - Wait states are unbounded.
  - `PcSrc` and `Stall` are ignored in FETCH.
- ISSUE: `Imem_Req`=0 and `Instr_Valid`=1.
  - `Stall`=1: hold all state.
  - `Stall`=0, `PcSrc`=0: `Pc`<=`Pc`+4; `Instr`<=`NOP_INSTR`; `Instr_Valid`<=0; go to FETCH.
  - `Stall`=0, `PcSrc`=1, `PcTarget[1:0]`=0: `Pc`<=`PcTarget`; otherwise as the `PcSrc`=0 case.
  - `Stall`=0, `PcSrc`=1, `PcTarget[1:0]`≠0: `Pc` unchanged; `Misalign_Err`<=1; `Instr`<=`NOP_INSTR`; `Instr_Valid`<=0; go to HALT.
- HALT: `Imem_Req`=0 and `Instr_Valid`=0. Only reset exits HALT.
- `Imem_Ready` outside FETCH is ignored. A `Stall` of 1 has priority over `PcSrc`.
- PC arithmetic is 32-bit unsigned. 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no error.
- `Op` and `PcPlus4` are combinational from the registers `Instr` and `Pc`.

## Timing
- Reset values (applied asynchronously while `rst_n`=0):
  - `Pc`=`RESET_PC`, `PcPlus4`=`RESET_PC`+4, `Imem_Addr`=`RESET_PC`.
  - `Instr`=`NOP_INSTR`, `Op`=7'b0010011.
  - `Instr_Valid`=0, `Imem_Req`=0, `Misalign_Err`=0.
  - FSM in IDLE.
- Reset released: first edge enters FETCH, so `Imem_Req`=1 in cycle 1.
- Zero-wait memory (`Imem_Ready`=1 in the first FETCH cycle):
  - `Instr_Valid`=1 one edge after `Imem_Req` rises.
  - The next `Imem_Req` follows one cycle after ISSUE when `Stall`=0.
  - Throughput is one instruction per 2 cycles.
- N wait states add N cycles in FETCH.
- `rst_n` asserted in any state, including FETCH with a request outstanding:
  - all outputs return to reset values immediately;
  - `Imem_Req` drops without waiting for `Imem_Ready`;
  - any in-flight read data is discarded.

## Test plan
- Reset: hold `rst_n`=0 with `RESET_PC`=0 → `Pc`=0, `PcPlus4`=4, `Instr`=0x00000013, `Op`=0010011, `Imem_Req`=0, `Instr_Valid`=0; after release `Imem_Req`=1 on cycle 1 with `Imem_Addr`=0.
- Sequential fetch, zero-wait: memory returns 0x00002083, then 0x00112023, then 0x002081B3.
  - `Op` sequence is 0000011, 0100011, 0110011.
  - `Pc` sequence is 0, 4, 8.
  - `Instr_Valid` pulses every 2nd cycle.
- Wait states: `Imem_Ready` low for 3 cycles at `Pc`=4 → `Imem_Addr` holds 4 and `Imem_Req` stays 1 for 4 cycles; `Instr_Valid` rises on the edge after `Imem_Ready`.
- Stall and redirect:
  - `Stall`=1 for 5 cycles in ISSUE → `Instr`, `Pc` and `Instr_Valid` held; `Imem_Req`=0 throughout.
  - Then `PcSrc`=1 with `PcTarget`=0x40 → next `Imem_Addr`=0x40 and a jal word 0x0000006F yields `Op`=1101111.
- Misaligned redirect: `PcSrc`=1, `PcTarget`=0x42 → `Misalign_Err`=1 and `Pc` unchanged; `Imem_Req` stays 0 for 20 cycles; reset clears it.
- Reset mid-fetch: assert `rst_n`=0 while in FETCH at `Pc`=0x10 with `Imem_Ready`=0 → `Imem_Req` drops immediately and `Pc`=0; a late `Imem_Ready` pulse has no effect.
